// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decode/issue sequencer for the 16-bit ALU.
// It accepts instruction words on a valid/ready handshake and reads operands
// from an internal register file. It drives the ALU for one EXEC cycle, then
// writes the captured result back in WB.
// Optional feature: define ALU_ZERO_FLAG_EN to add the zero_flag output.
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_inp1,
  output logic [DATA_W-1:0] alu_inp2,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out1,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal,
`ifdef ALU_ZERO_FLAG_EN
  output logic              zero_flag,
`endif
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   inp1_q, inp1_d;
  logic [DATA_W-1:0]   inp2_q, inp2_d;
  logic [2:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [DATA_W-1:0]   rf_q [NREG];

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   rd_f, rs_f, rt_f;
  logic [DATA_W-1:0]   imm_zx;
  logic [3:0]          dec;

  // Returns {legal, alu_sel} for an opcode; undefined opcodes come back as 0.
  function automatic logic [3:0] decode_op(input logic [3:0] op);
    case (op)
      4'd0:    return {1'b1, 3'b000};  // ADD
      4'd1:    return {1'b1, 3'b001};  // SUB
      4'd2:    return {1'b1, 3'b010};  // AND
      4'd3:    return {1'b1, 3'b011};  // OR
      4'd4:    return {1'b1, 3'b100};  // XOR
      4'd5:    return {1'b1, 3'b101};  // MOV rs
      4'd6:    return {1'b1, 3'b110};  // MOV rt
      4'd8:    return {1'b1, 3'b110};  // LDI: passes inp2 (the immediate)
      default: return 4'b0000;
    endcase
  endfunction

  assign opcode = instr[15:12];
  assign rd_f   = instr[9 +: ADDR_W];
  assign rs_f   = instr[6 +: ADDR_W];
  assign rt_f   = instr[3 +: ADDR_W];
  assign imm_zx = {{(DATA_W-9){1'b0}}, instr[8:0]};
  assign dec    = decode_op(opcode);

  assign alu_inp1 = inp1_q;
  assign alu_inp2 = inp2_q;
  assign alu_sel  = sel_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  // r0 is never written, so it always holds its reset value of zero.
  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

  // Next-state, datapath next values and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    inp1_d      = inp1_q;
    inp2_d      = inp2_q;
    sel_d       = sel_q;
    rd_d        = rd_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (dec[3]) begin
            // Operands are read here, after any earlier write-back has landed.
            state_d = EXEC;
            inp1_d  = rf_q[rs_f];
            inp2_d  = (opcode == 4'd8) ? imm_zx : rf_q[rt_f];
            sel_d   = dec[2:0];
            rd_d    = rd_f;
          end else begin
            state_d = ERR;
          end
        end
      end
      EXEC: begin
        wb_data_d = alu_out1;
        wb_addr_d = rd_q;
        state_d   = WB;
      end
      WB: begin
        wb_valid = 1'b1;
        state_d  = IDLE;
      end
      ERR: begin
        illegal = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and ALU/write-back holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      inp1_q    <= '0;
      inp2_q    <= '0;
      sel_q     <= 3'b000;
      rd_q      <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      inp1_q    <= inp1_d;
      inp2_q    <= inp2_d;
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Register file: written at the end of WB; writes to r0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (state_q == WB && wb_addr_q != '0) begin
      rf_q[wb_addr_q] <= wb_data_q;
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  logic zero_flag_q;
  assign zero_flag = zero_flag_q;

  // Zero flag follows every write-back (r0 included) and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag_q <= 1'b0;
    end else if (state_q == WB) begin
      zero_flag_q <= (wb_data_q == '0);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              instr_valid = 1'b0;
  logic [15:0]       instr = '0;
  logic              instr_ready;
  logic [DATA_W-1:0] alu_inp1, alu_inp2, alu_out1;
  logic [2:0]        alu_sel;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              illegal;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data;
`ifdef ALU_ZERO_FLAG_EN
  logic              zero_flag;
`endif

  alu_issue_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2),
    .alu_sel(alu_sel), .alu_out1(alu_out1), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal),
`ifdef ALU_ZERO_FLAG_EN
    .zero_flag(zero_flag),
`endif
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural 16-bit ALU the sequencer drives.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_out1 = alu_inp1 + alu_inp2;
      3'b001:  alu_out1 = alu_inp1 - alu_inp2;
      3'b010:  alu_out1 = alu_inp1 & alu_inp2;
      3'b011:  alu_out1 = alu_inp1 | alu_inp2;
      3'b100:  alu_out1 = alu_inp1 ^ alu_inp2;
      3'b101:  alu_out1 = alu_inp1;
      3'b110:  alu_out1 = alu_inp2;
      default: alu_out1 = '0;
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] rf_m [8];
  logic        zf_m = 1'b0;

  typedef struct {
    logic [15:0] w;
    logic        ill;
    logic [2:0]  sel;
    logic [15:0] i1;
    logic [15:0] i2;
    logic [2:0]  rd;
    logic [15:0] data;
    logic [2:0]  dbg_a;
    logic [15:0] dbg_v;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference semantics straight from the instruction set description.
  function automatic void model(input logic [15:0] w, output logic ill, output logic [2:0] sel,
                                output logic [15:0] a, output logic [15:0] b,
                                output logic [2:0] rd, output logic [15:0] res);
    rd = w[11:9];
    a = rf_m[w[8:6]];
    b = rf_m[w[5:3]];
    ill = 1'b0;
    sel = 3'b000;
    res = '0;
    case (w[15:12])
      4'd0: begin sel = 3'd0; res = a + b; end
      4'd1: begin sel = 3'd1; res = a - b; end
      4'd2: begin sel = 3'd2; res = a & b; end
      4'd3: begin sel = 3'd3; res = a | b; end
      4'd4: begin sel = 3'd4; res = a ^ b; end
      4'd5: begin sel = 3'd5; res = a; end
      4'd6: begin sel = 3'd6; res = b; end
      4'd8: begin sel = 3'd6; b = {7'd0, w[8:0]}; res = b; end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    zf_m = 1'b0;
  endtask

  task automatic dbg_check(input logic [2:0] a, input logic [15:0] v);
    dbg_addr = a;
    #1;
    check($sformatf("dbg_r%0d", a), dbg_data, v);
  endtask

  // Issues one word and checks EXEC operands, then either the WB pulse or the ERR pulse.
  task automatic run_instr(input logic [15:0] w, input logic ill, input logic [2:0] sel,
                           input logic [15:0] i1, input logic [15:0] i2,
                           input logic [2:0] rd, input logic [15:0] data);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!instr_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_issue", instr_ready, 1);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    @(negedge clk);
    check("ready_busy", instr_ready, 0);
    if (ill) begin
      check("illegal_pulse", illegal, 1);
      check("no_wb_on_err", wb_valid, 0);
      @(negedge clk);
      check("illegal_one_cycle", illegal, 0);
      check("ready_after_err", instr_ready, 1);
`ifdef ALU_ZERO_FLAG_EN
      check("zero_flag_hold", zero_flag, zf_m);
`endif
    end else begin
      check("exec_sel", alu_sel, sel);
      check("exec_inp1", alu_inp1, i1);
      check("exec_inp2", alu_inp2, i2);
      check("no_illegal", illegal, 0);
      @(negedge clk);
      check("wb_valid", wb_valid, 1);
      check("wb_addr", wb_addr, rd);
      check("wb_data", wb_data, data);
      @(negedge clk);
      check("wb_one_cycle", wb_valid, 0);
      check("ready_after_wb", instr_ready, 1);
      if (rd != 3'd0) rf_m[rd] = data;
      zf_m = (data == 16'h0);
`ifdef ALU_ZERO_FLAG_EN
      check("zero_flag", zero_flag, zf_m);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic ill_m;
    logic [2:0] sel_m, rd_m;
    logic [15:0] a_m, b_m, res_m, w;
    int rdy_cnt, wb_cnt;

    vecs[0]  = '{16'h8205, 1'b0, 3'b110, 16'h0000, 16'h0005, 3'd1, 16'h0005, 3'd1, 16'h0005};
    vecs[1]  = '{16'h8403, 1'b0, 3'b110, 16'h0000, 16'h0003, 3'd2, 16'h0003, 3'd2, 16'h0003};
    vecs[2]  = '{16'h0650, 1'b0, 3'b000, 16'h0005, 16'h0003, 3'd3, 16'h0008, 3'd3, 16'h0008};
    vecs[3]  = '{16'h1888, 1'b0, 3'b001, 16'h0003, 16'h0005, 3'd4, 16'hFFFE, 3'd4, 16'hFFFE};
    vecs[4]  = '{16'h4A48, 1'b0, 3'b100, 16'h0005, 16'h0005, 3'd5, 16'h0000, 3'd1, 16'h0005};
    vecs[5]  = '{16'hF000, 1'b1, 3'b000, 16'h0000, 16'h0000, 3'd0, 16'h0000, 3'd3, 16'h0008};
    vecs[6]  = '{16'h0050, 1'b0, 3'b000, 16'h0005, 16'h0003, 3'd0, 16'h0008, 3'd0, 16'h0000};
    vecs[7]  = '{16'h2CE0, 1'b0, 3'b010, 16'h0008, 16'hFFFE, 3'd6, 16'h0008, 3'd6, 16'h0008};
    vecs[8]  = '{16'h3E50, 1'b0, 3'b011, 16'h0005, 16'h0003, 3'd7, 16'h0007, 3'd7, 16'h0007};
    vecs[9]  = '{16'h5300, 1'b0, 3'b101, 16'hFFFE, 16'h0000, 3'd1, 16'hFFFE, 3'd1, 16'hFFFE};
    vecs[10] = '{16'h6438, 1'b0, 3'b110, 16'h0000, 16'h0007, 3'd2, 16'h0007, 3'd2, 16'h0007};
    vecs[11] = '{16'h7000, 1'b1, 3'b000, 16'h0000, 16'h0000, 3'd0, 16'h0000, 3'd2, 16'h0007};
    vecs[12] = '{16'h9FFF, 1'b1, 3'b000, 16'h0000, 16'h0000, 3'd0, 16'h0000, 3'd1, 16'hFFFE};
    vecs[13] = '{16'h87FF, 1'b0, 3'b110, 16'h0007, 16'h01FF, 3'd3, 16'h01FF, 3'd3, 16'h01FF};

    clear_model();

    // Reset state
    #12;
    check("rst_ready", instr_ready, 1);
    check("rst_inp1", alu_inp1, 0);
    check("rst_inp2", alu_inp2, 0);
    check("rst_sel", alu_sel, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_illegal", illegal, 0);
`ifdef ALU_ZERO_FLAG_EN
    check("rst_zero_flag", zero_flag, 0);
`endif
    dbg_check(3'd1, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_instr(vecs[i].w, vecs[i].ill, vecs[i].sel, vecs[i].i1, vecs[i].i2, vecs[i].rd, vecs[i].data);
      dbg_check(vecs[i].dbg_a, vecs[i].dbg_v);
    end

    // Back-to-back: valid held high, ready must pulse every third cycle
    @(negedge clk);
    instr = 16'h0650;
    instr_valid = 1'b1;
    rdy_cnt = 0;
    wb_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("b2b_ready_c%0d", k), instr_ready, (k % 3 == 0) ? 1 : 0);
      if (instr_ready) rdy_cnt++;
      if (wb_valid) wb_cnt++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("b2b_ready_count", rdy_cnt, 3);
    check("b2b_wb_count", wb_cnt, 3);
    rf_m[3] = rf_m[1] + rf_m[2];
    dbg_check(3'd3, rf_m[3]);

    // Randomized instructions against the reference model
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom);
      w[15:12] = 4'($urandom_range(0, 15));
      model(w, ill_m, sel_m, a_m, b_m, rd_m, res_m);
      run_instr(w, ill_m, sel_m, a_m, b_m, rd_m, res_m);
      w[2:0] = 3'($urandom_range(0, 7));
      dbg_check(w[2:0], rf_m[w[2:0]]);
    end

    // Reset in the middle of EXEC aborts the instruction without writing
    run_instr(16'h8205, 1'b0, 3'b110, rf_m[0], 16'h0005, 3'd1, 16'h0005);
    run_instr(16'h8403, 1'b0, 3'b110, rf_m[0], 16'h0003, 3'd2, 16'h0003);
    run_instr(16'h87FF, 1'b0, 3'b110, rf_m[7], 16'h01FF, 3'd3, 16'h01FF);
    @(negedge clk);
    instr = 16'h0650;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("pre_abort_sel", alu_sel, 3'b000);
    rst_n = 1'b0;
    #1;
    check("abort_inp1", alu_inp1, 0);
    check("abort_inp2", alu_inp2, 0);
    check("abort_wb_valid", wb_valid, 0);
    check("abort_wb_data", wb_data, 0);
    check("abort_ready", instr_ready, 1);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_wb", wb_valid, 0);
    dbg_check(3'd3, 16'h0000);
    dbg_check(3'd1, 16'h0000);
    run_instr(16'h8205, 1'b0, 3'b110, 16'h0000, 16'h0005, 3'd1, 16'h0005);
    dbg_check(3'd1, 16'h0005);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
